// File: rtl/mips_defs_pkg.sv
// ----------------------------------------------------------------------------
// mips_defs : shared definitions for the MIPS fetch stage.
//   NPC_*        next-PC source encodings driven by the D-stage decoder
//   DEF_*        default vector / address-window constants
//   fetch_state_t  RUN / HOLD state of the fetch PC controller
// ----------------------------------------------------------------------------
package mips_defs;

   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC     = 32'h0000_4180;
   localparam logic [31:0] DEF_ERET_OFFSET = 32'd4;
   localparam logic [31:0] DEF_TEXT_LO     = 32'h0000_3000;
   localparam logic [31:0] DEF_TEXT_HI     = 32'h0000_6ffc;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// ----------------------------------------------------------------------------
// npc_calc : combinational redirect-target generation.
//   Inputs : npc_sel, d_pc, br_off16, j_index26, reg_target, epc, eret
//   Outputs: redir_tgt (selected redirect target), redir (a redirect is
//            requested this cycle), ert (eret return address)
// All arithmetic is 32-bit modulo; carries out of bit 31 are dropped.
// ----------------------------------------------------------------------------
module npc_calc
   import mips_defs::*;
#(
   parameter logic [31:0] ERET_OFFSET = DEF_ERET_OFFSET
) (
   input  logic [1:0]  npc_sel,
   input  logic [31:0] d_pc,
   input  logic [15:0] br_off16,
   input  logic [25:0] j_index26,
   input  logic [31:0] reg_target,
   input  logic [31:0] epc,
   input  logic        eret,
   output logic [31:0] redir_tgt,
   output logic        redir,
   output logic [31:0] ert
);

   logic signed [31:0] br_off;
   logic        [31:0] br_tgt;
   logic        [31:0] j_tgt;

   // Word offset, sign-extended: a negative immediate branches backwards.
   assign br_off = signed'({{14{br_off16[15]}}, br_off16, 2'b00});
   assign br_tgt = d_pc + 32'd4 + $unsigned(br_off);
   assign j_tgt  = {d_pc[31:28], j_index26, 2'b00};
   assign ert    = epc + ERET_OFFSET;

   always_comb begin
      redir_tgt = d_pc + 32'd4;
      if (eret) begin
         redir_tgt = ert;
      end else begin
         unique case (npc_sel)
            NPC_BR:  redir_tgt = br_tgt;
            NPC_J:   redir_tgt = j_tgt;
            NPC_JR:  redir_tgt = reg_target;
            default: redir_tgt = d_pc + 32'd4;
         endcase
      end
   end

   assign redir = eret | (npc_sel != NPC_SEQ);

endmodule

// File: rtl/fetch_pc_unit.sv
// ----------------------------------------------------------------------------
// fetch_pc_unit : fetch-stage program counter with pending-redirect latch.
//   clk, reset       clock / asynchronous active-high reset
//   stall            D-stage hazard stall, holds the PC
//   req              exception/interrupt request -> EXC_VEC
//   eret, epc        exception return to epc + ERET_OFFSET
//   npc_sel, d_pc, br_off16, j_index26, reg_target   D-stage redirect info
//   pc_out           current fetch PC (register output)
//   pc_adel          fetch-address error for pc_out (combinational)
//   redir_pend       a redirect is latched, waiting for the stall to drop
// ----------------------------------------------------------------------------
module fetch_pc_unit
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_VEC   = DEF_RESET_VEC,
   parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC,
   parameter logic [31:0] ERET_OFFSET = DEF_ERET_OFFSET,
   parameter logic [31:0] TEXT_LO     = DEF_TEXT_LO,
   parameter logic [31:0] TEXT_HI     = DEF_TEXT_HI,
   parameter bit          CHECK_RANGE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] d_pc,
   input  logic [15:0] br_off16,
   input  logic [25:0] j_index26,
   input  logic [31:0] reg_target,
   output logic [31:0] pc_out,
   output logic        pc_adel,
   output logic        redir_pend
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pend_tgt;
   logic [31:0]  redir_tgt;
   logic [31:0]  ert;
   logic         redir;

   npc_calc #(
      .ERET_OFFSET (ERET_OFFSET)
   ) u_npc_calc (
      .npc_sel    (npc_sel),
      .d_pc       (d_pc),
      .br_off16   (br_off16),
      .j_index26  (j_index26),
      .reg_target (reg_target),
      .epc        (epc),
      .eret       (eret),
      .redir_tgt  (redir_tgt),
      .redir      (redir),
      .ert        (ert)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_VEC;
         pend_tgt <= '0;
         state    <= ST_RUN;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (req) begin
                  pc <= EXC_VEC;
               end else if (stall) begin
                  // Capture the redirect so it survives the stall.
                  if (redir) begin
                     pend_tgt <= redir_tgt;
                     state    <= ST_HOLD;
                  end
               end else begin
                  pc <= redir ? redir_tgt : pc + 32'd4;
               end
            end
            ST_HOLD: begin
               if (req) begin
                  pc       <= EXC_VEC;
                  pend_tgt <= '0;
                  state    <= ST_RUN;
               end else if (stall) begin
                  // The re-presented D instruction must not re-redirect;
                  // only an eret may replace the latched target.
                  if (eret) pend_tgt <= ert;
               end else begin
                  pc    <= eret ? ert : pend_tgt;
                  state <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign pc_out     = pc;
   assign redir_pend = (state == ST_HOLD);
   assign pc_adel    = (pc[1:0] != 2'b00) |
                       (CHECK_RANGE & ((pc < TEXT_LO) | (pc > TEXT_HI)));

endmodule
